// File: rtl/wr_arb_ctrl.sv
// wr_arb_ctrl: write-side controller of an asynchronous FIFO shared by
// several requesters. A round-robin arbiter picks at most one requester per
// cycle, drives the memory write port, and maintains the binary/Gray write
// pointer together with the full, almost-full and overflow-diagnostic flags.
//
// Ports
//   wclk          write-domain clock
//   wrst          asynchronous active-low reset
//   req           per-requester write request (held until granted)
//   req_data      requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   wq2_read_ptr  Gray read pointer, already synchronized into wclk
//   grant         one-hot (or zero) write acceptance, combinational
//   wen/waddr     memory write enable / address, combinational
//   wdata         granted requester's data (zero when idle)
//   wptr          registered Gray write pointer for the read domain
//   wfull         registered full flag
//   walmost_full  registered almost-full flag
//   wovf          sticky starvation-while-full diagnostic
`timescale 1ns/1ps
module wr_arb_ctrl #(
  parameter int unsigned ADDRESS_BITS = 9,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned AFULL_MARGIN = 4
) (
  input  logic                            wclk,
  input  logic                            wrst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [ADDRESS_BITS:0]           wq2_read_ptr,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            wen,
  output logic [ADDRESS_BITS-1:0]         waddr,
  output logic [DATA_WIDTH-1:0]           wdata,
  output logic [ADDRESS_BITS:0]           wptr,
  output logic                            wfull,
  output logic                            walmost_full,
  output logic                            wovf
);

  localparam int unsigned PW  = ADDRESS_BITS + 1;
  localparam int unsigned CW  = ADDRESS_BITS + 2;
  localparam int unsigned RRW = $clog2(NUM_REQ);
  localparam logic [CW-1:0] DEPTH     = {2'b01, {ADDRESS_BITS{1'b0}}};
  localparam logic [CW-1:0] TWO_DEPTH = {2'b10, {ADDRESS_BITS{1'b0}}};
  localparam logic [CW-1:0] MARGIN    = CW'(AFULL_MARGIN);

  logic [PW-1:0]  wbin, wbin_next, wgray_next, rbin, used;
  logic [CW-1:0]  free_cnt, rej_cnt;
  logic [RRW-1:0] rr_ptr, gidx, rr_next, scan_idx;
  logic           found, full_next, afull_next, rejecting;

  // Round-robin search starting at rr_ptr. Reset and full both suppress
  // every grant, so no write can slip through in the cycle wfull rises.
  always_comb begin
    grant    = '0;
    gidx     = '0;
    found    = 1'b0;
    scan_idx = '0;
    if (wrst && !wfull) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        scan_idx = RRW'((32'(rr_ptr) + off) % NUM_REQ);
        if (!found && req[scan_idx]) begin
          found = 1'b1;
          gidx  = scan_idx;
        end
      end
    end
    if (found) grant[gidx] = 1'b1;
  end

  assign wen   = found;
  assign waddr = wbin[ADDRESS_BITS-1:0];
  assign wdata = found ? req_data[32'(gidx)*DATA_WIDTH +: DATA_WIDTH] : '0;

  // Read pointer back to binary so the fill level can be computed.
  always_comb begin
    rbin = wq2_read_ptr;
    for (int unsigned k = 0; k < ADDRESS_BITS; k++) begin
      rbin[ADDRESS_BITS-1-k] = rbin[ADDRESS_BITS-k] ^ wq2_read_ptr[ADDRESS_BITS-1-k];
    end
  end

  always_comb begin
    wbin_next  = wbin + PW'(wen);
    wgray_next = wbin_next ^ (wbin_next >> 1);
    // Full when the next write pointer is exactly one lap ahead of the
    // read pointer: Gray form differs in the top two bits only.
    full_next  = (wgray_next == {~wq2_read_ptr[ADDRESS_BITS -: 2],
                                 wq2_read_ptr[ADDRESS_BITS-2:0]});
    used       = wbin_next - rbin;
    free_cnt   = DEPTH - {1'b0, used};
    afull_next = (free_cnt <= MARGIN);
    rr_next    = (32'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
    rejecting  = wfull && (|req);
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      rr_ptr       <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wovf         <= 1'b0;
      rej_cnt      <= '0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= full_next;
      walmost_full <= afull_next;
      if (wen) rr_ptr <= rr_next;
      // rej_cnt holds the number of earlier consecutive rejected cycles;
      // the flag trips on the cycle that exceeds twice the depth.
      if (rejecting) begin
        if (rej_cnt != '1) rej_cnt <= rej_cnt + 1'b1;
        if (rej_cnt >= TWO_DEPTH) wovf <= 1'b1;
      end else begin
        rej_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/wr_arb_ctrl.md
WR_ARB_CTRL -- requirements
Module: wr_arb_ctrl

Interface
REQ-001 SHALL have parameter ADDRESS_BITS, default 9: FIFO address width; depth = 2**ADDRESS_BITS.
REQ-002 SHALL have parameter NUM_REQ, default 4: number of write requesters, range 2..8.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: write data width per requester.
REQ-004 SHALL have parameter AFULL_MARGIN, default 4: number of free entries at or below which almost-full asserts.
REQ-005 SHALL have port wclk, input, 1: write-domain clock.
REQ-006 SHALL have port wrst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port req, input, NUM_REQ: per-requester write request, held until granted.
REQ-008 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH: requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port wq2_read_ptr, input, ADDRESS_BITS+1: Gray read pointer, already two-flop synchronized into wclk.
REQ-010 SHALL have port grant, output, NUM_REQ: one-hot or zero, write accepted this cycle.
REQ-011 SHALL have port wen, output, 1: memory write enable.
REQ-012 SHALL have port waddr, output, ADDRESS_BITS: memory write address.
REQ-013 SHALL have port wdata, output, DATA_WIDTH: granted requester's data.
REQ-014 SHALL have port wptr, output, ADDRESS_BITS+1: registered Gray write pointer, sent to read-domain synchronizer.
REQ-015 SHALL have port wfull, output, 1: registered full flag.
REQ-016 SHALL have port walmost_full, output, 1: registered almost-full flag.
REQ-017 SHALL have port wovf, output, 1: sticky error flag.

Function
REQ-018 SHALL keep an internal binary write pointer wbin, ADDRESS_BITS+1 bits; wptr = registered Gray of wbin ((b>>1)^b).
REQ-019 SHALL compute grant combinationally: zero when wfull=1; otherwise one-hot to the first asserted req at or after index rr_ptr, wrapping modulo NUM_REQ.
REQ-020 SHALL drive wen = |grant, waddr = wbin[ADDRESS_BITS-1:0], and wdata = the req_data slice of the granted index (zero when wen=0), all in the same cycle.
REQ-021 SHALL, on each wclk posedge with wen=1, increment wbin by 1 (wrapping 2**(ADDRESS_BITS+1)->0) and set rr_ptr = (granted index + 1) mod NUM_REQ; rr_ptr SHALL hold when wen=0.
REQ-022 SHALL register wfull each cycle as (Gray(wbin_next) == {~wq2_read_ptr[A:A-1], wq2_read_ptr[A-2:0]}), A=ADDRESS_BITS, where wbin_next = wbin + wen.
REQ-023 SHALL compute used = wbin_next - bin(wq2_read_ptr) (Gray-to-binary, modulo 2**(A+1)) and register walmost_full = (depth - used <= AFULL_MARGIN).
REQ-024 SHALL accept at most one write per cycle; the latency from req to grant SHALL be 0 cycles when not full and the requester holds priority.
REQ-025 SHALL guarantee fairness: a continuously asserted req SHALL be granted within NUM_REQ non-full cycles.
REQ-026 SHALL set wovf=1 if any req is asserted in a cycle where wfull=1 and a requester is rejected for more than 2*depth consecutive cycles; wovf SHALL clear only on reset (diagnostic only, no effect on data path).
REQ-027 SHALL never issue wen=1 while wfull=1, including the cycle in which wfull rises.
REQ-028 SHALL deassert wfull no earlier than the first wclk edge after wq2_read_ptr advances (pessimistic full, no data loss).

Reset
REQ-029 SHALL, while wrst=0, force wbin=0, wptr=0, rr_ptr=0, wfull=0, walmost_full=0, wovf=0; grant, wen, and wdata SHALL be 0 regardless of req.
REQ-030 SHALL take effect asynchronously on wrst fall, mid-write included; the first grant SHALL be possible in the first cycle after wrst rises.

Verification
REQ-031 SHALL verify: reset, then req=4'b1111 every cycle, wq2_read_ptr=0 -> grant sequence 0001,0010,0100,1000,0001..., waddr 0,1,2,3,...
REQ-032 SHALL verify: 512 writes with wq2_read_ptr=0 -> wfull=1 after the 512th edge, wptr=10'b1100000000, grant=0 thereafter; walmost_full=1 from used=508.
REQ-033 SHALL verify: from full, set wq2_read_ptr=Gray(1) -> wfull=0 next edge, one write at waddr 0, then wfull=1 again.
REQ-034 SHALL verify: req=4'b0100 only -> grant=0100 every cycle; wdata=req_data[23:16].
REQ-035 SHALL verify: pointer wrap after 1024 writes with read pointer tracking -> wbin wraps to 0, wptr Gray continuous (single-bit change per write), no false full.
REQ-036 SHALL verify: wrst pulsed low mid-burst -> all outputs 0 asynchronously; after release, grant restarts at requester 0.
